// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register read counts, write-pending and dirty flags.
// Define REG_SCOREBOARD_ERROR_EN to add the err_sticky overflow/misuse flag.
module reg_scoreboard #(
  parameter int REG_COUNT  = 16,
  parameter int ADDR_W     = 4,
  parameter int READ_PORTS = 2,
  parameter int CNT_W      = 3,
  parameter int EXT_REG    = 14
) (
  input  logic                         clk,
  input  logic                         async_rst_n,
  input  logic                         clk_en,
  input  logic                         sync_rst,
  input  logic [READ_PORTS-1:0]        rd_claim_valid,
  input  logic [READ_PORTS*ADDR_W-1:0] rd_claim_addr,
  input  logic                         wr_claim_valid,
  input  logic [ADDR_W-1:0]            wr_claim_addr,
  input  logic                         wr_claim_dirty,
  input  logic [READ_PORTS-1:0]        rd_release_valid,
  input  logic [READ_PORTS*ADDR_W-1:0] rd_release_addr,
  input  logic                         load_valid,
  input  logic [ADDR_W-1:0]            load_addr,
  input  logic                         wb_valid,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic                         ext_dirty,
  input  logic                         ext_to_be_written,
  input  logic                         ext_to_be_read,
  output logic [REG_COUNT-1:0]         dirty_vec,
  output logic [REG_COUNT-1:0]         to_be_written_vec,
  output logic [REG_COUNT-1:0]         to_be_read_vec,
  output logic [REG_COUNT*CNT_W-1:0]   read_count_flat
`ifdef REG_SCOREBOARD_ERROR_EN
  ,
  output logic                         err_sticky
`endif
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [REG_COUNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_COUNT-1:0]            tbw_q, tbw_d;
  logic [REG_COUNT-1:0]            dirty_q, dirty_d;
  logic                            err_q, err_d;
  logic                            err_ev;

  int  inc, dec, sum;
  logic wr_set, clr;

  always_comb begin
    cnt_d   = cnt_q;
    tbw_d   = tbw_q;
    dirty_d = dirty_q;
    err_ev  = 1'b0;
    inc     = 0;
    dec     = 0;
    sum     = 0;
    wr_set  = 1'b0;
    clr     = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      inc = 0;
      dec = 0;
      for (int p = 0; p < READ_PORTS; p++) begin
        if (rd_claim_valid[p] &&
            rd_claim_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i))
          inc = inc + 1;
        if (rd_release_valid[p] &&
            rd_release_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i))
          dec = dec + 1;
      end
      sum    = int'(cnt_q[i]) + inc - dec;
      wr_set = wr_claim_valid && (wr_claim_addr == ADDR_W'(i));
      clr    = (wb_valid && (wb_addr == ADDR_W'(i))) ||
               (load_valid && (load_addr == ADDR_W'(i)));
      if (i == EXT_REG) begin
        cnt_d[i]   = '0;
        tbw_d[i]   = 1'b0;
        dirty_d[i] = 1'b0;
      end else begin
        if (sum > CNT_MAX) begin
          cnt_d[i] = CNT_W'(CNT_MAX);
          err_ev   = 1'b1;
        end else if (sum < 0) begin
          cnt_d[i] = '0;
          err_ev   = 1'b1;
        end else begin
          cnt_d[i] = CNT_W'(sum);
        end
        // A claim wins over a same-cycle completion on the same register
        if (wr_set && tbw_q[i] && !clr)
          err_ev = 1'b1;
        tbw_d[i]   = wr_set ? 1'b1 : (clr ? 1'b0 : tbw_q[i]);
        dirty_d[i] = (wr_set && wr_claim_dirty) ? 1'b1 :
                     (clr ? 1'b0 : dirty_q[i]);
      end
    end
    err_d = err_q | err_ev;
    if (sync_rst) begin
      cnt_d   = '0;
      tbw_d   = '0;
      dirty_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      cnt_q   <= '0;
      tbw_q   <= '0;
      dirty_q <= '0;
      err_q   <= 1'b0;
    end else if (clk_en) begin
      cnt_q   <= cnt_d;
      tbw_q   <= tbw_d;
      dirty_q <= dirty_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_out
    if (i == EXT_REG) begin : g_ext
      assign dirty_vec[i]         = ext_dirty;
      assign to_be_written_vec[i] = ext_to_be_written;
      assign to_be_read_vec[i]    = ext_to_be_read;
      assign read_count_flat[i*CNT_W +: CNT_W] = '0;
    end else begin : g_int
      assign dirty_vec[i]         = dirty_q[i];
      assign to_be_written_vec[i] = tbw_q[i];
      assign to_be_read_vec[i]    = (cnt_q[i] != '0);
      assign read_count_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  if (EXT_REG >= REG_COUNT) begin : g_no_ext
    logic unused_ext;
    assign unused_ext = ext_dirty ^ ext_to_be_written ^ ext_to_be_read;
  end

`ifdef REG_SCOREBOARD_ERROR_EN
  assign err_sticky = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16: number of tracked architectural registers.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width; the value SHALL be at least $clog2(REG_COUNT).
REQ-003 SHALL have parameter READ_PORTS, default 2: number of read-claim ports and number of read-release ports.
REQ-004 SHALL have parameter CNT_W, default 3: width of each per-register outstanding-read counter.
REQ-005 SHALL have parameter EXT_REG, default 14: index whose status is supplied externally (stack top); EXT_REG >= REG_COUNT disables the exception.
REQ-006 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  async_rst_n  in  1  asynchronous reset, active low
  clk_en  in  1  state update enable
  sync_rst  in  1  synchronous clear, qualified by clk_en
  rd_claim_valid  in  READ_PORTS  decode registers pending operand read
  rd_claim_addr  in  READ_PORTS*ADDR_W  claimed register per port
  wr_claim_valid  in  1  decode reserves destination register
  wr_claim_addr  in  ADDR_W  destination register
  wr_claim_dirty  in  1  reservation also marks register dirty
  rd_release_valid  in  READ_PORTS  issue has consumed operand
  rd_release_addr  in  READ_PORTS*ADDR_W  released register per port
  load_valid  in  1  load return completes pending write
  load_addr  in  ADDR_W  load target
  wb_valid  in  1  ALU writeback completes pending write
  wb_addr  in  ADDR_W  writeback target
  ext_dirty, ext_to_be_written, ext_to_be_read  in  1 each  status for EXT_REG
  dirty_vec  out  REG_COUNT  dirty flags
  to_be_written_vec  out  REG_COUNT  write-pending flags
  to_be_read_vec  out  REG_COUNT  read-count non-zero flags
  read_count_flat  out  REG_COUNT*CNT_W  per-register outstanding-read counts
  err_sticky  out  1  present only under REQ-024

Function
REQ-007 All state SHALL be registered; an update applied at edge N SHALL be visible on the outputs after edge N with no combinational input-to-output path, except for EXT_REG.
REQ-008 With clk_en low, all state SHALL hold; all inputs except async_rst_n SHALL be ignored.
REQ-009 Per register, the next count SHALL be count + (number of valid claim ports addressing it) - (number of valid release ports addressing it), evaluated as one signed net in a single cycle.
REQ-010 A positive net change exceeding 2^CNT_W-1-count SHALL saturate the count at 2^CNT_W-1.
REQ-011 A negative net change exceeding count SHALL clamp the count at 0.
REQ-012 Equal claims and releases to the same register in one cycle SHALL leave the count unchanged.
REQ-013 to_be_read_vec[i] SHALL equal (count[i] != 0).
REQ-014 A wr_claim SHALL set to_be_written[addr]; wr_claim with wr_claim_dirty SHALL additionally set dirty[addr].
REQ-015 A valid wb or load SHALL clear to_be_written[addr] and dirty[addr].
REQ-016 When a wr_claim and a wb or load hit the same register in the same cycle, the set SHALL take precedence; dirty SHALL be set only if wr_claim_dirty is high.
REQ-017 Simultaneous wb and load to the same register SHALL clear it once with no error.
REQ-018 For i == EXT_REG, the three vector bits SHALL be driven combinationally from the ext_* inputs, the read count SHALL read 0, and all internal updates addressing EXT_REG SHALL be discarded.
REQ-019 Addresses >= REG_COUNT SHALL be ignored.

Reset
REQ-020 async_rst_n low SHALL immediately clear every counter, to_be_written, dirty and err_sticky, regardless of clk_en.
REQ-021 sync_rst high with clk_en high SHALL produce the same cleared state at the next edge, overriding all simultaneous claims, releases and writebacks.
REQ-022 Reset asserted while reads are outstanding SHALL discard them; releases arriving after reset SHALL clamp at 0 per REQ-011.

Configuration
REQ-023 Without REG_SCOREBOARD_ERROR_EN, port err_sticky SHALL be absent and saturation and clamping SHALL be silent.
REQ-024 With REG_SCOREBOARD_ERROR_EN, err_sticky SHALL set on any of: saturation (REQ-010), clamping (REQ-011), or wr_claim to a register already write-pending without a same-cycle clear; it SHALL stay set until reset.

Verification
REQ-025 Claim reg 3 on both ports, then release one port on the next cycle -> count[3] goes 2 then 1; to_be_read_vec[3] = 1 throughout.
REQ-026 CNT_W=3: claim reg 5 twice per cycle for 4 cycles -> count[5] = 7 and holds; err_sticky = 1 only with the macro defined.
REQ-027 Claim reg 2 with wr_claim_dirty, and wb reg 2 in the same cycle -> to_be_written[2] = 1 and dirty[2] = 1; wb on the next cycle -> both 0.
REQ-028 Set ext_to_be_read = 1 and claim reg 14 -> to_be_read_vec[14] = 1 in the same cycle; count[14] = 0; dropping ext_to_be_read -> 0.
REQ-029 Build counts on regs 0-3, then pulse async_rst_n low mid-cycle -> all outputs are 0 before the next edge; a subsequent release of reg 0 leaves count[0] = 0.
